// File: rtl/pwm_cap_core.sv
// -----------------------------------------------------------------------------
// pwm_cap_core
//
// PWM input capture. Measures the period and the high time of an external,
// asynchronous PWM waveform in prescaled ticks, and reports one result per
// completed period. It is the receive-side partner of the PWM generator and
// sits behind a register wrapper or feeds a control loop directly.
//
// Signal path:
//   pwm_i -> SYNC_STAGES-flop synchroniser -> [glitch filter] -> s_pwm
//   s_pwm plus a one-cycle-delayed copy give the rise / fall strobes.
//   A prescaler produces one tick per psc_i+1 clock cycles and restarts on
//   every detected rise, so measurements are phase-aligned to the waveform.
//   A 4-state FSM (IDLE, ARM, HIGH, LOW) turns edges and ticks into results.
//
// Build option:
//   PWM_CAP_FILTER_EN  when defined, s_pwm only follows the synchronised level
//                      after FLT_LEN consecutive identical samples (FLT_LEN>=2),
//                      so pulses shorter than FLT_LEN cycles are dropped and
//                      edge latency grows by FLT_LEN-1 cycles. When undefined,
//                      s_pwm is the last synchroniser stage.
//
// Parameters:
//   CNT_WIDTH    width of tick counter, psc_i, period_o, high_o
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FLT_LEN      filter length in cycles (filter build only)
//
// Ports:
//   clk_i     in   1          single clock
//   rst_i     in   1          synchronous, active-high reset
//   en_i      in   1          capture enable; low forces IDLE and clears work regs
//   psc_i     in   CNT_WIDTH  prescaler: one tick per psc_i+1 cycles (read live,
//                             change only while en_i=0)
//   pwm_i     in   1          asynchronous PWM input
//   period_o  out  CNT_WIDTH  last captured period, in ticks
//   high_o    out  CNT_WIDTH  last captured high time, in ticks
//   valid_o   out  1          1-cycle pulse: period_o/high_o just updated
//   ovf_o     out  1          1-cycle pulse: measurement timed out
//   busy_o    out  1          FSM is in HIGH or LOW
// -----------------------------------------------------------------------------
module pwm_cap_core #(
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FLT_LEN     = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [CNT_WIDTH-1:0] psc_i,
   input  logic                 pwm_i,
   output logic [CNT_WIDTH-1:0] period_o,
   output logic [CNT_WIDTH-1:0] high_o,
   output logic                 valid_o,
   output logic                 ovf_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   // ---------------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_lvl;
   logic                   s_pwm;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Optional glitch filter
   // ---------------------------------------------------------------------------
`ifdef PWM_CAP_FILTER_EN
   // flt_win holds the current synced sample in bit 0 and the FLT_LEN-1
   // previous ones above it; the filtered level only moves when all agree.
   logic [FLT_LEN-2:0] flt_hist_q, flt_hist_d;
   logic               flt_q, flt_d;
   logic [FLT_LEN-1:0] flt_win;
   logic               flt_stable;

   always_comb begin
      flt_win    = {flt_hist_q, sync_lvl};
      flt_stable = (&flt_win) | ~(|flt_win);
      s_pwm      = flt_stable ? sync_lvl : flt_q;
      flt_d      = s_pwm;
      flt_hist_d = flt_win[FLT_LEN-2:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flt_hist_q <= '0;
         flt_q      <= 1'b0;
      end else begin
         flt_hist_q <= flt_hist_d;
         flt_q      <= flt_d;
      end
   end
`else
   // Unfiltered build: the synchroniser output is used directly. FLT_LEN has
   // no effect here; both branches are identical.
   if (FLT_LEN > 0) begin : g_direct
      assign s_pwm = sync_lvl;
   end else begin : g_direct_len0
      assign s_pwm = sync_lvl;
   end
`endif

   // ---------------------------------------------------------------------------
   // Edge detect, prescaler, tick counter, FSM
   // ---------------------------------------------------------------------------
   logic                 pwm_prev_q, pwm_prev_d;
   logic                 rise, fall;
   logic [CNT_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
   logic                 tick;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] cap;
   logic                 timeout;
   logic [CNT_WIDTH-1:0] high_q, high_d;
   logic [CNT_WIDTH-1:0] period_out_q, period_out_d;
   logic [CNT_WIDTH-1:0] high_out_q, high_out_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;
   state_t               state_q, state_d;

   assign rise = s_pwm & ~pwm_prev_q;
   assign fall = ~s_pwm & pwm_prev_q;

   // The tick is evaluated on rise cycles too: it closes the period that just
   // ended (folded into cap) while the prescaler restarts for the next one.
   assign tick = (psc_cnt_q == psc_i);

   // Count including this cycle's tick, so edge captures never lose the tick
   // that coincides with the edge.
   assign cap = cnt_q + (tick ? CNT_ONE : CNT_ZERO);

   // A tick that would carry the counter past all-ones ends the measurement.
   assign timeout = tick && (cnt_q == CNT_MAX);

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      sync_d       = {sync_q[SYNC_STAGES-2:0], pwm_i};
      pwm_prev_d   = s_pwm;
      psc_cnt_d    = psc_cnt_q;
      state_d      = state_q;
      cnt_d        = cnt_q;
      high_d       = high_q;
      period_out_d = period_out_q;
      high_out_d   = high_out_q;
      valid_d      = 1'b0;
      ovf_d        = 1'b0;

      // Prescaler: restart on every rise so tick phase follows the waveform.
      if (!en_i) begin
         psc_cnt_d = CNT_ZERO;
      end else if (rise || tick) begin
         psc_cnt_d = CNT_ZERO;
      end else begin
         psc_cnt_d = psc_cnt_q + CNT_ONE;
      end

      if (!en_i) begin
         // Disable discards any partial measurement; published results hold.
         state_d = ST_IDLE;
         cnt_d   = CNT_ZERO;
         high_d  = CNT_ZERO;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = CNT_ZERO;
            end

            // The level present at enable is ignored; only a real rise starts
            // a measurement.
            ST_ARM: begin
               if (rise) begin
                  state_d = ST_HIGH;
                  cnt_d   = CNT_ZERO;
               end
            end

            // The counter runs on through the fall: period is rise to rise.
            ST_HIGH: begin
               if (fall) begin
                  high_d  = cap;
                  cnt_d   = cap;
                  state_d = ST_LOW;
               end else if (timeout) begin
                  ovf_d   = 1'b1;
                  state_d = ST_ARM;
                  cnt_d   = CNT_ZERO;
                  high_d  = CNT_ZERO;
               end else if (tick) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            // A rise closes the period and opens the next one in the same cycle.
            ST_LOW: begin
               if (rise) begin
                  period_out_d = cap;
                  high_out_d   = high_q;
                  valid_d      = 1'b1;
                  cnt_d        = CNT_ZERO;
                  state_d      = ST_HIGH;
               end else if (timeout) begin
                  ovf_d   = 1'b1;
                  state_d = ST_ARM;
                  cnt_d   = CNT_ZERO;
                  high_d  = CNT_ZERO;
               end else if (tick) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the values computed in the previous cycle regardless of order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q       <= '0;
         pwm_prev_q   <= 1'b0;
         psc_cnt_q    <= CNT_ZERO;
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         high_q       <= CNT_ZERO;
         period_out_q <= CNT_ZERO;
         high_out_q   <= CNT_ZERO;
         valid_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         pwm_prev_q   <= pwm_prev_d;
         psc_cnt_q    <= psc_cnt_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         high_q       <= high_d;
         period_out_q <= period_out_d;
         high_out_q   <= high_out_d;
         valid_q      <= valid_d;
         ovf_q        <= ovf_d;
      end
   end

   assign period_o = period_out_q;
   assign high_o   = high_out_q;
   assign valid_o  = valid_q;
   assign ovf_o    = ovf_q;
   assign busy_o   = (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule

// File: tb/tb_pwm_cap_core.sv
// -----------------------------------------------------------------------------
// tb_pwm_cap_core
//
// Self-checking bench for pwm_cap_core (CNT_WIDTH=8 so the timeout is short).
// The stimulus tasks drive pwm_i and, from the cycle numbers at which they
// drive edges, derive the expected period/high results, pushing them onto a
// scoreboard queue. A negedge monitor pops one entry for every valid_o/ovf_o
// pulse and compares kind, values and latency from the driving edge.
// The expectations follow PWM_CAP_FILTER_EN the same way the DUT build does.
// -----------------------------------------------------------------------------
module tb_pwm_cap_core;

   localparam int CW   = 8;
   localparam int SYNC = 2;
   localparam int FLT  = 3;
`ifdef PWM_CAP_FILTER_EN
   localparam int LAT  = SYNC + 1 + FLT - 1;
`else
   localparam int LAT  = SYNC + 1;
`endif
   localparam int OVF_SPAN = 1 << CW;
   localparam int EV_VALID = 1;
   localparam int EV_OVF   = 2;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          en_i;
   logic [CW-1:0] psc_i;
   logic          pwm_i;
   logic [CW-1:0] period_o;
   logic [CW-1:0] high_o;
   logic          valid_o;
   logic          ovf_o;
   logic          busy_o;

   pwm_cap_core #(
      .CNT_WIDTH   (CW),
      .SYNC_STAGES (SYNC),
      .FLT_LEN     (FLT)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .psc_i    (psc_i),
      .pwm_i    (pwm_i),
      .period_o (period_o),
      .high_o   (high_o),
      .valid_o  (valid_o),
      .ovf_o    (ovf_o),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int per;
      int hi;
      int ref_cyc;
      int lat;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_psc;
   bit m_have_rise;
   bit m_have_fall;
   int m_rise_cyc;
   int m_fall_cyc;
   int m_period;
   int m_high;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int kind, input int per, input int hi,
                           input int ref_cyc, input int lat);
      exp_t e;
      e.kind    = kind;
      e.per     = per;
      e.hi      = hi;
      e.ref_cyc = ref_cyc;
      e.lat     = lat;
      sb.push_back(e);
   endtask

   task automatic model_disarm();
      m_have_rise = 1'b0;
      m_have_fall = 1'b0;
   endtask

   // Drive a new pwm level; when 'seen' is set the model treats it as an edge
   // the capture logic will act on.
   task automatic set_pwm(input logic v, input bit seen);
      pwm_i = v;
      if (seen) begin
         if (v) begin
            if (m_have_rise && m_have_fall) begin
               m_period = (cyc - m_rise_cyc) / (m_psc + 1);
               m_high   = (m_fall_cyc - m_rise_cyc) / (m_psc + 1);
               push_exp(EV_VALID, m_period, m_high, cyc, LAT);
            end
            m_have_rise = 1'b1;
            m_have_fall = 1'b0;
            m_rise_cyc  = cyc;
         end else if (m_have_rise) begin
            m_have_fall = 1'b1;
            m_fall_cyc  = cyc;
         end
      end
   endtask

   task automatic run_wave(input int n, input int per, input int hi);
      for (int i = 0; i < n; i++) begin
         set_pwm(1'b1, 1'b1);
         wait_cycles(hi);
         set_pwm(1'b0, 1'b1);
         wait_cycles(per - hi);
      end
   endtask

   task automatic enable_capture(input int psc);
      en_i = 1'b0;
      wait_cycles(2);
      psc_i = CW'(psc);
      m_psc = psc;
      wait_cycles(1);
      en_i = 1'b1;
      model_disarm();
      wait_cycles(3);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (valid_o || ovf_o) begin
         check("valid_ovf_exclusive", int'(valid_o & ovf_o), 0);
         if (sb.size() == 0) begin
            check("unexpected_event", valid_o ? EV_VALID : EV_OVF, 0);
         end else begin
            e = sb.pop_front();
            check("event_kind", valid_o ? EV_VALID : EV_OVF, e.kind);
            check("event_period_o", int'(period_o), e.per);
            check("event_high_o", int'(high_o), e.hi);
            check("event_latency", cyc - e.ref_cyc, e.lat);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ref_cyc;
      rst_i = 1'b1;
      en_i  = 1'b0;
      pwm_i = 1'b0;
      psc_i = '0;
      m_psc = 0;
      m_period = 0;
      m_high   = 0;
      model_disarm();
      wait_cycles(3);

      check("reset_period_o", int'(period_o), 0);
      check("reset_high_o", int'(high_o), 0);
      check("reset_valid_o", int'(valid_o), 0);
      check("reset_ovf_o", int'(ovf_o), 0);
      check("reset_busy_o", int'(busy_o), 0);
      rst_i = 1'b0;
      wait_cycles(2);

      // T1: psc=0, period 10, high 3
      enable_capture(0);
      run_wave(4, 10, 3);
      check("t1_busy_in_low", int'(busy_o), 1);
      wait_cycles(5);
      check("t1_period_o", int'(period_o), 10);
      check("t1_high_o", int'(high_o), 3);

      // T2: psc=3, period 40, high 12 -> 10/3 ticks
      enable_capture(3);
      run_wave(3, 40, 12);
      wait_cycles(5);
      check("t2_period_o", int'(period_o), 10);
      check("t2_high_o", int'(high_o), 3);

      // T3: timeout with input held high, then held low
      enable_capture(0);
      set_pwm(1'b1, 1'b1);
      push_exp(EV_OVF, m_period, m_high, cyc, LAT + OVF_SPAN);
      wait_cycles(OVF_SPAN + 20);
      model_disarm();
      check("t3_high_busy_after_ovf", int'(busy_o), 0);
      check("t3_high_period_hold", int'(period_o), 10);
      set_pwm(1'b0, 1'b1);
      wait_cycles(5);
      set_pwm(1'b1, 1'b1);
      ref_cyc = cyc;
      wait_cycles(3);
      set_pwm(1'b0, 1'b1);
      push_exp(EV_OVF, m_period, m_high, ref_cyc, LAT + OVF_SPAN);
      wait_cycles(OVF_SPAN + 20);
      model_disarm();
      check("t3_low_busy_after_ovf", int'(busy_o), 0);
      check("t3_low_high_hold", int'(high_o), 3);
      run_wave(2, 10, 3);
      wait_cycles(5);

      // T4: enable dropped mid-HIGH after a valid, then re-enabled
      enable_capture(0);
      run_wave(1, 10, 3);
      set_pwm(1'b1, 1'b1);
      wait_cycles(6);
      check("t4_busy_before_drop", int'(busy_o), 1);
      en_i = 1'b0;
      model_disarm();
      wait_cycles(1);
      check("t4_busy_after_drop", int'(busy_o), 0);
      check("t4_valid_after_drop", int'(valid_o), 0);
      check("t4_period_hold", int'(period_o), 10);
      check("t4_high_hold", int'(high_o), 3);
      set_pwm(1'b0, 1'b1);
      wait_cycles(5);
      en_i = 1'b1;
      wait_cycles(3);
      run_wave(2, 10, 3);
      wait_cycles(5);

      // T5: one-cycle glitch in the middle of the low phase
      enable_capture(0);
      set_pwm(1'b1, 1'b1);
      wait_cycles(3);
      set_pwm(1'b0, 1'b1);
      wait_cycles(3);
`ifdef PWM_CAP_FILTER_EN
      set_pwm(1'b1, 1'b0);
      wait_cycles(1);
      set_pwm(1'b0, 1'b0);
`else
      set_pwm(1'b1, 1'b1);
      wait_cycles(1);
      set_pwm(1'b0, 1'b1);
`endif
      wait_cycles(3);
      set_pwm(1'b1, 1'b1);
      wait_cycles(3);
      set_pwm(1'b0, 1'b1);
      wait_cycles(7);
      set_pwm(1'b1, 1'b1);
      wait_cycles(3);
      set_pwm(1'b0, 1'b1);
      wait_cycles(10);
      check("t5_period_o", int'(period_o), 10);
      check("t5_high_o", int'(high_o), 3);

      // T6: one-cycle reset in the middle of the low phase
      enable_capture(0);
      run_wave(1, 10, 3);
      set_pwm(1'b1, 1'b1);
      wait_cycles(3);
      set_pwm(1'b0, 1'b1);
      wait_cycles(6);
      check("t6_busy_before_rst", int'(busy_o), 1);
      rst_i = 1'b1;
      wait_cycles(1);
      check("t6_rst_period_o", int'(period_o), 0);
      check("t6_rst_high_o", int'(high_o), 0);
      check("t6_rst_valid_o", int'(valid_o), 0);
      check("t6_rst_ovf_o", int'(ovf_o), 0);
      check("t6_rst_busy_o", int'(busy_o), 0);
      m_period = 0;
      m_high   = 0;
      model_disarm();
      rst_i = 1'b0;
      wait_cycles(3);
      run_wave(2, 10, 3);
      wait_cycles(5);
      check("t6_period_after_restart", int'(period_o), 10);
      check("t6_high_after_restart", int'(high_o), 3);

      wait_cycles(20);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
